mem_port_arbiter: RTL and testbench

//  Shares the single-ported main memory (addr/inData/outData/W) between two masters: port 0 = CPU core, port 1 = DMA/display.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port main-memory arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 16;

    // Access sequencing: grant in IDLE, drive memory in ISSUE, wait out read latency in WAIT.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Requester identities; the value doubles as the port index.
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin pick: a lone requester wins; on a tie the port
// that was not granted last wins.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic winner
);

    // Winner selection from current requests and previous grant.
    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req1) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between the CPU core (port 0)
// and the DMA/display engine (port 1). One access in flight, registered
// memory-side outputs, read data returned with a one-cycle valid strobe.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    port_e             last_gnt_q, last_gnt_d;
    port_e             cur_port_q, cur_port_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              pick_valid;
    logic              pick_winner;

    rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

    // Next-state and datapath: latch the winner's command in IDLE, hold it
    // through ISSUE, count down the read latency in WAIT and capture data.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cur_port_d  = cur_port_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    if (pick_winner) begin
                        mem_addr_d  = addr1;
                        mem_wdata_d = wdata1;
                        mem_we_d    = we1;
                        gnt1_d      = 1'b1;
                    end else begin
                        mem_addr_d  = addr0;
                        mem_wdata_d = wdata0;
                        mem_we_d    = we0;
                        gnt0_d      = 1'b1;
                    end
                    last_gnt_d = port_e'(pick_winner);
                    cur_port_d = port_e'(pick_winner);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (cur_port_q == PORT_DMA) begin
                        rdata1_d  = mem_rdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_rdata;
                        rvalid0_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= PORT_DMA;
            cur_port_q  <= PORT_CPU;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cur_port_q  <= cur_port_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: an occupancy-based reference model
// predicts grants, memory writes and read returns; a negedge monitor pops and
// compares. A second instance with RD_LAT=2 covers the longer read latency.
module tb_mem_port_arbiter;

    localparam int unsigned LAT1 = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [14:0] mem_addr;

    logic        b_req0 = 1'b0, b_req1 = 1'b0, b_we0 = 1'b0, b_we1 = 1'b0;
    logic [14:0] b_addr0 = '0, b_addr1 = '0;
    logic [15:0] b_wdata0 = '0, b_wdata1 = '0;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we;
    logic [15:0] b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata, b_pipe;
    logic [14:0] b_mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .RD_LAT(LAT1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata)
    );

    // Block RAMs: one-cycle registered read (instance 1), two-cycle (instance 2).
    logic [15:0] mem  [0:32767];
    logic [15:0] mem2 [0:32767];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (b_mem_we) mem2[b_mem_addr] <= b_mem_wdata;
        b_pipe      <= mem2[b_mem_addr];
        b_mem_rdata <= b_pipe;
    end

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access is accepted on an edge when the arbiter is
    // free; a write occupies 2 cycles, a read 2+RD_LAT cycles.
    typedef struct { int unsigned c; logic p; } gev_t;
    typedef struct { int unsigned c; logic [14:0] a; logic [15:0] d; } wev_t;
    typedef struct { int unsigned c; logic [15:0] d; } rev_t;

    gev_t gq[$];
    wev_t wq[$];
    rev_t rq0[$];
    rev_t rq1[$];
    gev_t gnt_log[$];

    logic [15:0] model_mem [0:32767];
    int unsigned cyc = 0;
    int unsigned busy = 0;
    logic        last_p = 1'b1;
    logic        rst_q = 1'b1;

    always @(posedge clk) begin
        logic        w;
        logic        m_we;
        logic [14:0] m_a;
        logic [15:0] m_d;
        cyc   <= cyc + 1;
        rst_q <= reset;
        if (reset) begin
            busy   = 0;
            last_p = 1'b1;
            gq.delete();
            wq.delete();
            rq0.delete();
            rq1.delete();
        end else if (busy != 0) begin
            busy = busy - 1;
        end else if (req0 || req1) begin
            w      = (req0 && req1) ? ~last_p : req1;
            last_p = w;
            m_we   = w ? we1 : we0;
            m_a    = w ? addr1 : addr0;
            m_d    = w ? wdata1 : wdata0;
            gq.push_back('{cyc + 1, w});
            if (m_we) begin
                wq.push_back('{cyc + 1, m_a, m_d});
                model_mem[m_a] = m_d;
                busy = 1;
            end else begin
                if (w) rq1.push_back('{cyc + 2 + LAT1, model_mem[m_a]});
                else   rq0.push_back('{cyc + 2 + LAT1, model_mem[m_a]});
                busy = 1 + LAT1;
            end
        end
    end

    // Monitor: pop expected events as the DUT presents them; flag overdue ones.
    logic [15:0] prev0 = '0, prev1 = '0;
    always @(negedge clk) begin
        gev_t g;
        wev_t wv;
        rev_t r;
        if (gnt0 || gnt1) begin
            gnt_log.push_back('{cyc, gnt1});
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
            end else begin
                g = gq.pop_front();
                chk("gnt_port", {30'd0, gnt1, gnt0}, g.p ? 32'd2 : 32'd1);
                chk("gnt_cycle", cyc, g.c);
            end
        end
        if (mem_we) begin
            if (wq.size() == 0) begin
                chk("mem_we_unexpected", 32'd1, 32'd0);
            end else begin
                wv = wq.pop_front();
                chk("wr_addr", {17'd0, mem_addr}, {17'd0, wv.a});
                chk("wr_data", {16'd0, mem_wdata}, {16'd0, wv.d});
                chk("wr_cycle", cyc, wv.c);
            end
        end
        if (rvalid0 && rvalid1) chk("rvalid_both", 32'd1, 32'd0);
        if (rvalid0) begin
            if (rq0.size() == 0) begin
                chk("rvalid0_unexpected", 32'd1, 32'd0);
            end else begin
                r = rq0.pop_front();
                chk("rdata0", {16'd0, rdata0}, {16'd0, r.d});
                chk("rvalid0_cycle", cyc, r.c);
            end
        end
        if (rvalid1) begin
            if (rq1.size() == 0) begin
                chk("rvalid1_unexpected", 32'd1, 32'd0);
            end else begin
                r = rq1.pop_front();
                chk("rdata1", {16'd0, rdata1}, {16'd0, r.d});
                chk("rvalid1_cycle", cyc, r.c);
            end
        end
        if (!rst_q) begin
            if (!rvalid0) chk("rdata0_hold", {16'd0, rdata0}, {16'd0, prev0});
            if (!rvalid1) chk("rdata1_hold", {16'd0, rdata1}, {16'd0, prev1});
        end
        prev0 = rdata0;
        prev1 = rdata1;
        while (gq.size() > 0 && gq[0].c < cyc) begin
            g = gq.pop_front();
            chk("gnt_missing", cyc, g.c);
        end
        while (wq.size() > 0 && wq[0].c < cyc) begin
            wv = wq.pop_front();
            chk("mem_we_missing", cyc, wv.c);
        end
        while (rq0.size() > 0 && rq0[0].c < cyc) begin
            r = rq0.pop_front();
            chk("rvalid0_missing", cyc, r.c);
        end
        while (rq1.size() > 0 && rq1[0].c < cyc) begin
            r = rq1.pop_front();
            chk("rvalid1_missing", cyc, r.c);
        end
    end

    // Present a request and hold it until the matching grant is seen.
    task automatic drive(input logic p, input logic w, input logic [14:0] a, input logic [15:0] d);
        logic got;
        got = 1'b0;
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) begin
                got = 1'b1;
                chk("issue_addr", {17'd0, mem_addr}, {17'd0, a});
                chk("issue_we", {31'd0, mem_we}, {31'd0, w});
            end
        end
        if (!got) chk("gnt_timeout", 32'd0, 32'd1);
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt_rvalid_we"}, {27'd0, gnt0, gnt1, rvalid0, rvalid1, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, {17'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        chk({tag, "_rdata"}, {rdata1, rdata0}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_rvalid0(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rvalid0) seen = 1'b1;
        end
    endtask

    initial begin
        logic        seen;
        logic        we_seen;
        int unsigned c0, cg, cr;
        logic [15:0] d2;

        for (int i = 0; i < 32768; i++) begin
            mem[i]       = 16'(i) ^ 16'hA5A5;
            model_mem[i] = 16'(i) ^ 16'hA5A5;
            mem2[i]      = '0;
        end
        mem[15'h2400]       = 16'h0001;
        model_mem[15'h2400] = 16'h0001;
        mem2[15'h0042]      = 16'h1234;

        repeat (2) @(negedge clk);
        check_reset_outputs("init");
        reset = 1'b0;

        // Read of a preloaded word by port 0.
        drive(1'b0, 1'b0, 15'h2400, 16'h0);
        wait_rvalid0(seen);
        chk("t1_rvalid_seen", {31'd0, seen}, 32'd1);
        chk("t1_rdata0", {16'd0, rdata0}, 32'h0001);

        // Write by port 1; no read strobe should follow.
        drive(1'b1, 1'b1, 15'h0600, 16'h0038);
        repeat (3) @(negedge clk);
        chk("t2_mem", {16'd0, mem[15'h0600]}, 32'h0038);

        // Simultaneous requests after reset alternate starting with port 0.
        do_reset();
        gnt_log.delete();
        fork
            begin drive(1'b0, 1'b1, 15'h0010, 16'h1111); drive(1'b0, 1'b1, 15'h0011, 16'h2222); end
            begin drive(1'b1, 1'b1, 15'h0020, 16'h3333); drive(1'b1, 1'b1, 15'h0021, 16'h4444); end
        join
        repeat (2) @(negedge clk);
        chk("t3_count", gnt_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk("t3_order", {31'd0, gnt_log[i].p}, (i % 2 == 1) ? 32'd1 : 32'd0);

        // Reset during the WAIT cycle of a port 0 read discards the read.
        drive(1'b0, 1'b0, 15'h0100, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t4");
        reset = 1'b0;
        drive(1'b1, 1'b0, 15'h0600, 16'h0);
        repeat (4) @(negedge clk);

        // Back-to-back writes from port 0: one grant every 2 cycles.
        gnt_log.delete();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 15'h0600 + 15'(i), 16'h0100 + 16'(i));
        repeat (2) @(negedge clk);
        chk("t6_count", gnt_log.size(), 32'd4);
        for (int i = 1; i < 4 && i < gnt_log.size(); i++)
            chk("t6_spacing", gnt_log[i].c - gnt_log[i-1].c, 32'd2);
        for (int i = 0; i < 4; i++)
            chk("t6_mem", {16'd0, mem[15'h0600 + 15'(i)]}, 32'h0100 + 32'(i));

        // Randomized traffic from both ports over a small address window.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    drive(1'b0, 1'($urandom_range(0, 1)), 15'h0100 + 15'($urandom_range(0, 7)), 16'($urandom));
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    drive(1'b1, 1'($urandom_range(0, 1)), 15'h0100 + 15'($urandom_range(0, 7)), 16'($urandom));
                end
            end
        join
        repeat (6) @(negedge clk);

        // RD_LAT=2 instance: read returns 4 cycles after the accepting edge.
        c0 = cyc;
        cg = 0;
        cr = 0;
        d2 = '0;
        we_seen = 1'b0;
        b_req0  = 1'b1;
        b_we0   = 1'b0;
        b_addr0 = 15'h0042;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_mem_we) we_seen = 1'b1;
            if (b_gnt0) begin
                cg = cyc;
                b_req0 = 1'b0;
                chk("t5_mem_addr", {17'd0, b_mem_addr}, 32'h0042);
            end
            if (b_rvalid0) begin
                cr = cyc;
                d2 = b_rdata0;
            end
        end
        b_req0 = 1'b0;
        chk("t5_gnt_cycle", cg, c0 + 1);
        chk("t5_rvalid_cycle", cr, c0 + 4);
        chk("t5_rdata", {16'd0, d2}, 32'h1234);
        chk("t5_no_we", {31'd0, we_seen}, 32'd0);

        chk("drain_gq", gq.size(), 32'd0);
        chk("drain_wq", wq.size(), 32'd0);
        chk("drain_rq", rq0.size() + rq1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
